// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU core: opcode encodings, the
// controller state type and the single- vs multi-cycle classification.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_MUL = 4'd5;
   localparam logic [3:0] OP_DIV = 4'd6;
   localparam logic [3:0] OP_CMP = 4'd7;
   localparam logic [3:0] OP_LDI = 4'd8;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   // Divide by zero resolves in a single cycle, so only a real divide iterates.
   function automatic logic is_multicycle(input logic [3:0] op, input logic b_is_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// clock, WIDTH steps per operation.
// Ports:
//   clk, reset     clock, async active-low reset
//   start          latch operands and begin (only while idle)
//   op             OP_MUL or OP_DIV
//   a, b           operands (b is multiplicand / divisor)
//   busy           steps remaining
//   done           this edge performs the final step; result/carry valid now
//   result, carry  outcome of the final step (low product + overflow, or quotient)
module seq_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]      cnt_q;
   logic               is_div_q;
   logic [WIDTH-1:0]   b_q;
   // Upper half: product accumulator (MUL) or partial remainder (DIV).
   // Lower half: remaining multiplier bits (MUL) or dividend/quotient (DIV).
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;

   always_comb begin
      mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
      div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      if (is_div_q) begin
         // Negative trial difference: restore the shifted remainder, quotient bit 0.
         if (div_diff[WIDTH])
            work_d = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
         else
            work_d = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
      end else begin
         work_d = {mul_sum, work_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         b_q      <= '0;
         work_q   <= '0;
      end else if (start && (cnt_q == '0)) begin
         cnt_q    <= CW'(WIDTH);
         is_div_q <= (op == OP_DIV);
         b_q      <= b;
         work_q   <= {{WIDTH{1'b0}}, a};
      end else if (cnt_q != '0) begin
         work_q <= work_d;
         cnt_q  <= cnt_q - 1'b1;
      end
   end

   assign busy   = (cnt_q != '0);
   assign done   = (cnt_q == CW'(1));
   assign result = work_d[WIDTH-1:0];
   assign carry  = !is_div_q && (work_d[2*WIDTH-1:WIDTH] != '0);

endmodule

// File: rtl/seq_alu_core.sv
// Sequential ALU core: register file, single-cycle ALU, valid/ready issue and
// an iterative MUL/DIV engine, with carry/zero/divide-by-zero flags.
// Ports:
//   clk, reset                      clock, async active-low reset
//   instr_valid/instr_ready         instruction handshake
//   opcode, rd, rs1, rs2, imm       instruction fields
//   wb_valid, wb_addr, wb_data      one-cycle writeback report (held otherwise)
//   flag_carry/zero/dbz             flags of the last completed op
//   dbg_addr -> dbg_data            combinational register-file read
//
// state | meaning
// IDLE  | accepting instructions; single-cycle ops complete on the accept edge
// BUSY  | MUL/DIV iterating; completes and returns to IDLE on the final step
module seq_alu_core
   import seq_alu_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int RA_W     = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       opcode,
   input  logic [RA_W-1:0]  rd,
   input  logic [RA_W-1:0]  rs1,
   input  logic [RA_W-1:0]  rs2,
   input  logic [WIDTH-1:0] imm,
   output logic             wb_valid,
   output logic [RA_W-1:0]  wb_addr,
   output logic [WIDTH-1:0] wb_data,
   output logic             flag_carry,
   output logic             flag_zero,
   output logic             flag_dbz,
   input  logic [RA_W-1:0]  dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   state_e           state_q;
   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [RA_W-1:0]  busy_rd_q;

   logic [WIDTH-1:0] op_a, op_b, alu_res, md_result;
   logic             alu_cy, alu_dbz, alu_wr, multi, md_start, md_busy, md_done, md_carry;

   assign op_a = regs_q[rs1];
   assign op_b = regs_q[rs2];
   assign multi = is_multicycle(opcode, op_b == '0);
   assign md_start = (state_q == IDLE) && instr_valid && multi;

   always_comb begin
      alu_res = '0;
      alu_cy  = 1'b0;
      alu_dbz = 1'b0;
      alu_wr  = 1'b1;
      case (opcode)
         OP_ADD: {alu_cy, alu_res} = {1'b0, op_a} + {1'b0, op_b};
         OP_SUB: begin
            alu_res = op_a - op_b;
            alu_cy  = (op_a < op_b);
         end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         OP_XOR: alu_res = op_a ^ op_b;
         OP_CMP: begin
            alu_res = (op_a == op_b) ? WIDTH'(1) : '0;
            alu_cy  = (op_a < op_b);
         end
         OP_LDI: alu_res = imm;
         OP_DIV: alu_dbz = (op_b == '0);
         OP_MUL: alu_res = '0;
         default: alu_wr = 1'b0;
      endcase
   end

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .op     (opcode),
      .a      (op_a),
      .b      (op_b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result),
      .carry  (md_carry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_rd_q  <= '0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         flag_carry <= 1'b0;
         flag_zero  <= 1'b0;
         flag_dbz   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (instr_valid) begin
                  if (multi) begin
                     state_q   <= BUSY;
                     busy_rd_q <= rd;
                  end else if (alu_wr) begin
                     regs_q[rd] <= alu_res;
                     wb_valid   <= 1'b1;
                     wb_addr    <= rd;
                     wb_data    <= alu_res;
                     flag_carry <= alu_cy;
                     flag_zero  <= (alu_res == '0);
                     flag_dbz   <= alu_dbz;
                  end
               end
            end
            BUSY: begin
               if (md_busy && md_done) begin
                  regs_q[busy_rd_q] <= md_result;
                  wb_valid   <= 1'b1;
                  wb_addr    <= busy_rd_q;
                  wb_data    <= md_result;
                  flag_carry <= md_carry;
                  flag_zero  <= (md_result == '0);
                  flag_dbz   <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
- Parametrised successor to the 8-bit control-unit/ALU/register datapath.
- Adds a NUM_REGS-entry register file, a valid/ready instruction handshake, and carry/zero/divide-by-zero flags.
- Adds an immediate-load opcode, plus multi-cycle shift-add multiply and restoring divide.
- Sits between the instruction fetch/decode front end and the writeback/debug observers.

Parameters:
WIDTH, 8, datapath and register width (>=4)
NUM_REGS, 8, register-file entries (power of 2, >=2)
RA_W, $clog2(NUM_REGS), register address width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
instr_valid  input  1  instruction present
instr_ready  output  1  core can accept an instruction this cycle
opcode  input  4  operation, encodings in seq_alu_pkg
rd  input  RA_W  destination register
rs1  input  RA_W  source A
rs2  input  RA_W  source B
imm  input  WIDTH  immediate for LDI
wb_valid  output  1  one-cycle pulse: a result was written
wb_addr  output  RA_W  register written
wb_data  output  WIDTH  value written
flag_carry  output  1  carry/borrow/overflow of last completed op
flag_zero  output  1  last completed result == 0
flag_dbz  output  1  last completed op was a divide by zero
dbg_addr  input  RA_W  debug read address
dbg_data  output  WIDTH  regfile[dbg_addr], combinational

Behaviour:
- Reset (reset==0, asynchronous):
  - All registers = 0; state = IDLE; instr_ready = 1 once released.
  - wb_valid, wb_addr, wb_data and all flags = 0.
  - Reset asserted mid-operation aborts the op: no writeback, no flag update.
- Opcodes (4 bits):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 CMP, 8 LDI.
  - 9..15 are NOP: accepted, nothing written, no wb_valid, flags unchanged.
- Handshake:
  - Accept at edge T when instr_valid && instr_ready.
  - instr_ready = (state == IDLE).
  - Operands are read combinationally from the register file at T.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, CMP, LDI, DIV-by-zero):
  - Register file and flags are written at edge T.
  - wb_valid = 1 for the cycle after T.
  - State stays IDLE, so back-to-back issue is supported with full throughput.
  - A following instruction reads the already-updated register (no hazard).
- ADD: {carry, result} = a + b, computed WIDTH+1 bits wide.
- SUB: result = a - b mod 2^WIDTH; carry = borrow (a < b unsigned).
- AND / OR / XOR: carry = 0.
- CMP: result = 1 if a == b, else 0; carry = (a < b) unsigned.
- LDI: result = imm; carry = 0.
- Zero flag: zero = (result == 0) for every completed op.
- Divide by zero: DIV with b == 0 gives result = 0, carry = 0, dbz = 1, single-cycle. Every other completed op clears dbz.
- MUL and DIV with b != 0 are multi-cycle:
  - Edge T: state -> BUSY, cnt = WIDTH; latch a, b, rd and the operation.
  - Each BUSY edge performs one shift-add or restoring-subtract step and decrements cnt.
  - The edge where cnt goes 1 -> 0 is T+WIDTH: write the register and flags, state -> IDLE.
  - wb_valid is high in cycle T+WIDTH+1.
  - instr_ready is low for cycles T+1 .. T+WIDTH, i.e. exactly WIDTH cycles.
- MUL result: result = low WIDTH bits of the 2*WIDTH-bit product; carry = (upper WIDTH bits != 0).
- DIV result: result = unsigned quotient; remainder discarded; carry = 0.
- While BUSY, instr_valid is ignored and opcode/rd/rs/imm are don't-care.
- wb_addr and wb_data hold their last value when wb_valid = 0.
- Flags hold between completions.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams OP_ADD .. OP_LDI;
  - state enum {IDLE, BUSY};
  - function is_multicycle(op, b_is_zero).
- One sub-module, seq_muldiv: iterative MUL/DIV engine.
  - Interface: start, op, a, b, busy, done, result, carry, parametrised by WIDTH.
- The register file and single-cycle ALU stay in the top module.

Test Plan:
1. WIDTH=8. Reset; LDI r1=200; LDI r2=100; ADD r3=r1+r2 -> wb_data=44, carry=1, zero=0; dbg r3 = 44.
2. SUB r4=r2-r1 -> 156, carry=1. SUB r5=r1-r1 -> 0, zero=1, carry=0. CMP r1,r2 -> 0, carry=0.
3. LDI r5=16; LDI r6=20; MUL r7=r5*r6 -> instr_ready low exactly 8 cycles; wb_valid at T+9; wb_data=64 (320 mod 256), carry=1.
4. DIV r1/r6 -> wb_data=10, latency 8, dbz=0. Then DIV r1/r0 (r0=0) -> wb_data=0, dbz=1, wb_valid at T+1, ready never drops.
5. Issue MUL, assert reset=0 in BUSY cycle 4 -> immediately ready=1 after release, all dbg reads 0, flags 0, no wb_valid ever.
6. Hold instr_valid with LDI r1=3, ADD r1=r1+r1, ADD r1=r1+r1 back-to-back -> ready stays 1; wb_valid 3 consecutive cycles with data 3, 6, 12.
